// File: rtl/aead_job_sequencer.sv
// aead_job_sequencer: job-level controller for the AES-GCM / ChaCha20-Poly1305
// datapath. It takes one descriptor at a time, configures the datapath, streams
// the AAD and payload beats with byte-keep masks derived from the descriptor
// lengths, issues the length block and returns the final tag.
module aead_job_sequencer #(
   parameter int TAG_TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst,
   // job descriptor
   input  logic         job_valid,
   output logic         job_ready,
   input  logic         job_algo,
   input  logic [15:0]  job_aad_len,
   input  logic [31:0]  job_pld_len,
   input  logic         abort,
   // upstream byte stream
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   // datapath configuration
   output logic         cfg_we,
   output logic         algo_sel,
   // AAD stream to the datapath
   output logic         aad_valid,
   input  logic         aad_ready,
   output logic [127:0] aad_data,
   output logic [15:0]  aad_keep,
   // payload stream to the datapath
   output logic         pld_valid,
   input  logic         pld_ready,
   output logic [127:0] pld_data,
   output logic [15:0]  pld_keep,
   // length block
   output logic         len_valid,
   input  logic         len_ready,
   output logic [127:0] len_block,
   // tag inputs from the datapath
   input  logic         tag_pre_xor_valid,
   input  logic [127:0] tag_pre_xor,
   input  logic         tagmask_valid,
   input  logic [127:0] tagmask,
   // result
   output logic         tag_valid,
   input  logic         tag_ready,
   output logic [127:0] tag_out,
   output logic         tag_err,
   output logic         busy
);

   localparam int TW = (TAG_TIMEOUT > 2) ? $clog2(TAG_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TAG_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG,
      S_AAD,
      S_PLD,
      S_LEN,
      S_TAG_WAIT,
      S_TAG_OUT
   } state_t;

   state_t         state_q, state_d;
   logic           algo_q, algo_d;
   logic [15:0]    rem_aad_q, rem_aad_d;
   logic [31:0]    rem_pld_q, rem_pld_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic           got_pre_q, got_pre_d;
   logic           got_mask_q, got_mask_d;
   logic [127:0]   tag_out_q, tag_out_d;
   logic           tag_err_q, tag_err_d;
   logic [127:0]   pre_q, mask_q, len_block_q;
   logic           job_acc;
   logic           got_pre_n, got_mask_n;
   logic [127:0]   pre_eff, mask_eff;

   // Keep mask for the beat carrying the next bytes; MSB is byte 0.
   function automatic logic [15:0] beat_keep(input logic [31:0] rem);
      if (rem >= 32'd16) return 16'hFFFF;
      else               return ~(16'hFFFF >> rem[3:0]);
   endfunction

   // Remaining byte count after one beat, saturating at zero.
   function automatic logic [31:0] beat_consume(input logic [31:0] rem);
      if (rem >= 32'd16) return rem - 32'd16;
      else               return 32'd0;
   endfunction

   // Next-state and output decode; abort overrides every other transition.
   always_comb begin
      state_d    = state_q;
      algo_d     = algo_q;
      rem_aad_d  = rem_aad_q;
      rem_pld_d  = rem_pld_q;
      tmo_d      = tmo_q;
      got_pre_d  = got_pre_q;
      got_mask_d = got_mask_q;
      tag_out_d  = tag_out_q;
      tag_err_d  = tag_err_q;
      job_acc    = 1'b0;
      job_ready  = (state_q == S_IDLE) && !abort;
      busy       = (state_q != S_IDLE);
      in_ready   = 1'b0;
      cfg_we     = 1'b0;
      aad_valid  = 1'b0;
      aad_data   = '0;
      aad_keep   = '0;
      pld_valid  = 1'b0;
      pld_data   = '0;
      pld_keep   = '0;
      len_valid  = 1'b0;
      tag_valid  = 1'b0;
      got_pre_n  = got_pre_q | tag_pre_xor_valid;
      got_mask_n = got_mask_q | tagmask_valid;
      pre_eff    = tag_pre_xor_valid ? tag_pre_xor : pre_q;
      mask_eff   = tagmask_valid ? tagmask : mask_q;

      case (state_q)
         S_IDLE: begin
            if (job_valid && !abort) begin
               job_acc   = 1'b1;
               algo_d    = job_algo;
               rem_aad_d = job_aad_len;
               rem_pld_d = job_pld_len;
               state_d   = S_CFG;
            end
         end
         S_CFG: begin
            cfg_we = 1'b1;
            if (rem_aad_q != 16'd0)      state_d = S_AAD;
            else if (rem_pld_q != 32'd0) state_d = S_PLD;
            else                         state_d = S_LEN;
         end
         S_AAD: begin
            aad_valid = in_valid;
            aad_data  = in_data;
            in_ready  = aad_ready;
            aad_keep  = beat_keep({16'b0, rem_aad_q});
            if (in_valid && aad_ready) begin
               rem_aad_d = 16'(beat_consume({16'b0, rem_aad_q}));
               if (rem_aad_q <= 16'd16)
                  state_d = (rem_pld_q != 32'd0) ? S_PLD : S_LEN;
            end
         end
         S_PLD: begin
            pld_valid = in_valid;
            pld_data  = in_data;
            in_ready  = pld_ready;
            pld_keep  = beat_keep(rem_pld_q);
            if (in_valid && pld_ready) begin
               rem_pld_d = beat_consume(rem_pld_q);
               if (rem_pld_q <= 32'd16) state_d = S_LEN;
            end
         end
         S_LEN: begin
            len_valid = 1'b1;
            if (len_ready) begin
               tmo_d      = '0;
               got_pre_d  = 1'b0;
               got_mask_d = 1'b0;
               state_d    = S_TAG_WAIT;
            end
         end
         S_TAG_WAIT: begin
            if (got_pre_n && got_mask_n) begin
               tag_out_d  = pre_eff ^ mask_eff;
               tag_err_d  = 1'b0;
               got_pre_d  = 1'b0;
               got_mask_d = 1'b0;
               state_d    = S_TAG_OUT;
            end else if (tmo_q == TMO_LAST) begin
               tag_out_d  = '0;
               tag_err_d  = 1'b1;
               got_pre_d  = 1'b0;
               got_mask_d = 1'b0;
               state_d    = S_TAG_OUT;
            end else begin
               tmo_d      = tmo_q + 1'b1;
               got_pre_d  = got_pre_n;
               got_mask_d = got_mask_n;
            end
         end
         S_TAG_OUT: begin
            tag_valid = 1'b1;
            if (tag_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && state_q != S_IDLE) begin
         state_d    = S_IDLE;
         rem_aad_d  = '0;
         rem_pld_d  = '0;
         tmo_d      = '0;
         got_pre_d  = 1'b0;
         got_mask_d = 1'b0;
         tag_out_d  = tag_out_q;
         tag_err_d  = tag_err_q;
      end
   end

   // Control state and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         algo_q     <= 1'b0;
         rem_aad_q  <= '0;
         rem_pld_q  <= '0;
         tmo_q      <= '0;
         got_pre_q  <= 1'b0;
         got_mask_q <= 1'b0;
         tag_out_q  <= '0;
         tag_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         algo_q     <= algo_d;
         rem_aad_q  <= rem_aad_d;
         rem_pld_q  <= rem_pld_d;
         tmo_q      <= tmo_d;
         got_pre_q  <= got_pre_d;
         got_mask_q <= got_mask_d;
         tag_out_q  <= tag_out_d;
         tag_err_q  <= tag_err_d;
      end
   end

   // Data captures: length block at job acceptance, tag halves while waiting.
   always_ff @(posedge clk) begin
      if (job_acc)
         len_block_q <= {45'b0, job_aad_len, 3'b0, 29'b0, job_pld_len, 3'b0};
      if (state_q == S_TAG_WAIT && tag_pre_xor_valid)
         pre_q <= tag_pre_xor;
      if (state_q == S_TAG_WAIT && tagmask_valid)
         mask_q <= tagmask;
   end

   assign algo_sel  = algo_q;
   assign len_block = len_block_q;
   assign tag_out   = tag_out_q;
   assign tag_err   = tag_err_q;

endmodule

// File: tb/tb_aead_job_sequencer.sv
// Directed bench for aead_job_sequencer: nominal job, zero-length job, tag
// ordering, timeout, abort and randomized stalls.
module tb_aead_job_sequencer;

   localparam int TMO = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         job_valid, job_ready, job_algo;
   logic [15:0]  job_aad_len;
   logic [31:0]  job_pld_len;
   logic         abort;
   logic         in_valid, in_ready;
   logic [127:0] in_data;
   logic         cfg_we, algo_sel;
   logic         aad_valid, aad_ready;
   logic [127:0] aad_data;
   logic [15:0]  aad_keep;
   logic         pld_valid, pld_ready;
   logic [127:0] pld_data;
   logic [15:0]  pld_keep;
   logic         len_valid, len_ready;
   logic [127:0] len_block;
   logic         tag_pre_xor_valid, tagmask_valid;
   logic [127:0] tag_pre_xor, tagmask;
   logic         tag_valid, tag_ready;
   logic [127:0] tag_out;
   logic         tag_err, busy;

   int n_tests = 0;
   int n_fail  = 0;

   aead_job_sequencer #(.TAG_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_algo(job_algo),
      .job_aad_len(job_aad_len), .job_pld_len(job_pld_len), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .cfg_we(cfg_we), .algo_sel(algo_sel),
      .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_data(aad_data), .aad_keep(aad_keep),
      .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data), .pld_keep(pld_keep),
      .len_valid(len_valid), .len_ready(len_ready), .len_block(len_block),
      .tag_pre_xor_valid(tag_pre_xor_valid), .tag_pre_xor(tag_pre_xor),
      .tagmask_valid(tagmask_valid), .tagmask(tagmask),
      .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_out(tag_out),
      .tag_err(tag_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] pat(input int i);
      return {4{32'hC0DE0000 + 32'(i)}};
   endfunction

   task automatic start_job(input logic algo, input logic [15:0] aad, input logic [31:0] pld);
      job_valid   = 1'b1;
      job_algo    = algo;
      job_aad_len = aad;
      job_pld_len = pld;
      tick();
      job_valid   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_keep [3];
      int          idx;
      int          cyc;
      logic        hs;
      logic [127:0] held;

      exp_keep = '{16'hFFFF, 16'hFFFF, 16'hFF00};
      rst = 1'b1;
      job_valid = 0; job_algo = 0; job_aad_len = 0; job_pld_len = 0; abort = 0;
      in_valid = 0; in_data = '0; aad_ready = 0; pld_ready = 0; len_ready = 0;
      tag_pre_xor_valid = 0; tag_pre_xor = '0; tagmask_valid = 0; tagmask = '0;
      tag_ready = 0;
      #3;
      check("rst_job_ready", job_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_cfg_we", cfg_we, 0);
      check("rst_tag_valid", tag_valid, 0);
      check("rst_len_valid", len_valid, 0);
      check("rst_algo_sel", algo_sel, 0);
      check("rst_tag_out", tag_out, 0);
      check("rst_keep", {aad_keep, pld_keep}, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // ---- nominal AES job: aad=20, pld=32
      start_job(1'b0, 16'd20, 32'd32);
      check("nom_cfg_we", cfg_we, 1);
      check("nom_cfg_busy", busy, 1);
      check("nom_cfg_job_ready", job_ready, 0);
      check("nom_cfg_in_ready", in_ready, 0);
      in_valid = 1; aad_ready = 1; in_data = pat(0);
      tick();
      check("nom_cfg_once", cfg_we, 0);
      check("nom_aad_keep0", aad_keep, 16'hFFFF);
      check("nom_aad_valid", aad_valid, 1);
      check("nom_aad_data0", aad_data, pat(0));
      check("nom_aad_in_ready", in_ready, 1);
      tick();
      in_data = pat(1);
      #1;
      check("nom_aad_keep1", aad_keep, 16'hF000);
      check("nom_aad_data1", aad_data, pat(1));
      pld_ready = 1;
      tick();
      in_data = pat(2);
      #1;
      check("nom_pld_keep0", pld_keep, 16'hFFFF);
      check("nom_pld_data0", pld_data, pat(2));
      check("nom_pld_aad_valid", aad_valid, 0);
      tick();
      check("nom_pld_keep1", pld_keep, 16'hFFFF);
      tick();
      in_valid = 0;
      #1;
      check("nom_len_valid", len_valid, 1);
      check("nom_len_block", len_block, 128'h00000000_000000A0_00000000_00000100);
      check("nom_len_in_ready", in_ready, 0);
      tick();
      check("nom_len_hold", len_valid, 1);
      len_ready = 1;
      tick();
      len_ready = 0;
      #1;
      check("nom_tw_len_valid", len_valid, 0);
      tag_pre_xor_valid = 1; tag_pre_xor = 128'h55;
      tagmask_valid = 1; tagmask = 128'h0F;
      tick();
      tag_pre_xor_valid = 0; tagmask_valid = 0;
      tag_pre_xor = '1; tagmask = '0;
      #1;
      check("nom_tag_valid", tag_valid, 1);
      check("nom_tag_out", tag_out, 128'h5A);
      check("nom_tag_err", tag_err, 0);
      tick();
      check("nom_tag_hold", tag_out, 128'h5A);
      tag_ready = 1;
      tick();
      tag_ready = 0;
      #1;
      check("nom_b2b_job_ready", job_ready, 1);
      check("nom_idle_tag_valid", tag_valid, 0);

      // ---- zero-length ChaCha job, mask arrives 5 cycles before pre
      start_job(1'b1, 16'd0, 32'd0);
      check("zl_cfg_algo", algo_sel, 1);
      check("zl_cfg_we", cfg_we, 1);
      in_valid = 1; aad_ready = 1; pld_ready = 1;
      tick();
      check("zl_len_valid", len_valid, 1);
      check("zl_len_block", len_block, 0);
      check("zl_no_stream", {aad_valid, pld_valid, in_ready}, 0);
      check("zl_len_algo", algo_sel, 1);
      len_ready = 1;
      tick();
      len_ready = 0; in_valid = 0; aad_ready = 0; pld_ready = 0;
      tagmask_valid = 1; tagmask = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      tick();
      tagmask_valid = 0; tagmask = '1;
      repeat (4) tick();
      check("zl_tw_wait", tag_valid, 0);
      check("zl_tw_algo", algo_sel, 1);
      tag_pre_xor_valid = 1; tag_pre_xor = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
      tick();
      tag_pre_xor_valid = 0;
      check("zl_tag_valid", tag_valid, 1);
      check("zl_tag_out", tag_out, 128'hFEDCBA98_89ABCDEF_01234567_76543210);
      check("zl_tag_err", tag_err, 0);
      check("zl_out_algo", algo_sel, 1);
      tag_ready = 1;
      tick();
      tag_ready = 0;
      check("zl_idle_algo", algo_sel, 1);

      // ---- timeout: no strobes
      start_job(1'b0, 16'd0, 32'd0);
      tick();
      len_ready = 1;
      tick();
      len_ready = 0;
      repeat (TMO - 1) tick();
      check("tmo_not_yet", tag_valid, 0);
      tick();
      check("tmo_tag_valid", tag_valid, 1);
      check("tmo_tag_err", tag_err, 1);
      check("tmo_tag_out", tag_out, 0);
      check("tmo_algo", algo_sel, 0);
      tag_ready = 1;
      tick();
      tag_ready = 0;
      check("tmo_idle", busy, 0);

      // ---- abort on 2nd of 4 payload beats
      start_job(1'b0, 16'd0, 32'd64);
      in_valid = 1; pld_ready = 1; in_data = pat(10);
      tick();
      check("ab_pld_keep", pld_keep, 16'hFFFF);
      tick();
      abort = 1;
      #1;
      check("ab_beat2_ready", in_ready, 1);
      tick();
      abort = 0;
      #1;
      check("ab_idle_busy", busy, 0);
      check("ab_idle_in_ready", in_ready, 0);
      check("ab_idle_pld", {pld_valid, pld_keep}, 0);
      check("ab_idle_tag_valid", tag_valid, 0);
      job_valid = 1; job_aad_len = 0; job_pld_len = 1; abort = 1;
      #1;
      check("ab_idle_block_ready", job_ready, 0);
      tick();
      check("ab_idle_block_busy", busy, 0);
      abort = 0;
      tick();
      job_valid = 0;
      check("ab_next_cfg", cfg_we, 1);
      tick();
      check("ab_next_keep", pld_keep, 16'h8000);
      check("ab_next_in_ready", in_ready, 1);
      tick();
      in_valid = 0; pld_ready = 0;
      check("ab_next_len", len_block, 128'h8);
      abort = 1;
      tick();
      abort = 0;
      #1;
      check("ab_len_idle", {busy, tag_valid, len_valid}, 0);

      // ---- randomized stalls: aad=5, pld=40
      start_job(1'b1, 16'd5, 32'd40);
      tick();
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 300) begin
         in_valid  = 1'($urandom_range(0, 1));
         aad_ready = 1'($urandom_range(0, 1));
         pld_ready = 1'($urandom_range(0, 1));
         in_data   = pat(20 + idx);
         #1;
         if (idx == 0) begin
            check("bp_aad_keep", aad_keep, 16'hF800);
            hs = aad_valid && aad_ready;
            if (hs) check("bp_aad_data", aad_data, pat(20));
         end else begin
            check("bp_pld_keep", pld_keep, exp_keep[idx-1]);
            hs = pld_valid && pld_ready;
            if (hs) check("bp_pld_data", pld_data, pat(20 + idx));
         end
         tick();
         if (hs) idx++;
         cyc++;
      end
      check("bp_beats", idx, 4);
      in_valid = 0; aad_ready = 0; pld_ready = 0;
      #1;
      check("bp_len_valid", len_valid, 1);
      check("bp_len_block", len_block, 128'h0000000000000028_0000000000000140);
      len_ready = 1;
      tick();
      len_ready = 0;
      tag_pre_xor_valid = 1; tag_pre_xor = {16{8'hA5}};
      tagmask_valid = 1; tagmask = {16{8'h0F}};
      tick();
      tag_pre_xor_valid = 0; tagmask_valid = 0;
      held = {16{8'hAA}};
      for (int k = 0; k < 3; k++) begin
         check("bp_tag_stall_valid", tag_valid, 1);
         check("bp_tag_stall_out", tag_out, held);
         tick();
      end
      tag_ready = 1;
      tick();
      tag_ready = 0;
      check("bp_done_idle", {busy, tag_valid}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aead_job_sequencer.md
# aead_job_sequencer

Job-level controller for the dual-algorithm AEAD datapath (AES-GCM / ChaCha20-Poly1305). It accepts one job descriptor at a time and configures the datapath with `cfg_we`. It then streams the AAD and payload beats from an upstream byte stream, deriving byte-keep masks from the descriptor lengths. It issues the length block, collects the pre-XOR tag and the tag mask, and returns the final tag. It sits between the host/DMA front end and the datapath top level, and is the only driver of that top level's `cfg_we`, stream, length and `algo_sel` inputs.

## Interface
- `TAG_TIMEOUT`, 1024: maximum number of cycles spent in TAG_WAIT before the job is failed.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `job_valid` / `job_ready`  in/out  1  descriptor handshake.
- `job_algo`  in  1  0=AES-GCM, 1=ChaCha20-Poly1305.
- `job_aad_len`  in  16  AAD length in bytes.
- `job_pld_len`  in  32  payload length in bytes.
- `abort`  in  1  synchronous job cancel.
- `in_valid` / `in_ready`  in/out  1  upstream data handshake (AAD beats then payload beats).
- `in_data`  in  128  upstream beat; byte 0 = `[127:120]`.
- `cfg_we`, `algo_sel`  out  1  datapath configuration.
- `aad_valid` / `aad_ready`  out/in  1  AAD beat handshake to the datapath.
- `aad_data`  out  128  AAD beat.
- `aad_keep`  out  16  AAD byte-keep mask.
- `pld_valid` / `pld_ready`  out/in  1  payload beat handshake to the datapath.
- `pld_data`  out  128  payload beat.
- `pld_keep`  out  16  payload byte-keep mask.
- `len_valid` / `len_ready`  out/in  1  length-block handshake.
- `len_block`  out  128  length block.
- `tag_pre_xor_valid`, `tag_pre_xor`  in  1/128  pre-XOR tag from the datapath.
- `tagmask_valid`, `tagmask`  in  1/128  tag mask from the datapath.
- `tag_valid` / `tag_ready`  out/in  1  result handshake.
- `tag_out`  out  128  final tag.
- `tag_err`  out  1  timeout flag, qualified by `tag_valid`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation

**States:** IDLE, CFG, AAD, PLD, LEN, TAG_WAIT, TAG_OUT.

- **IDLE**
  - `job_ready`=1.
  - On `job_valid`, latch algo and lengths, load `rem_aad` (16 b) and `rem_pld` (32 b), then go to CFG.
- **CFG**
  - `cfg_we`=1 for exactly one cycle.
  - Next state is AAD if aad_len≠0, else PLD if pld_len≠0, else LEN.
- **AAD / PLD**
  - Pass-through: `x_valid`=`in_valid`, `x_data`=`in_data`, `in_ready`=`x_ready`.
  - `in_ready`=0 in every other state.
  - Keep mask: `x_keep`=16'hFFFF if rem≥16, else `~(16'hFFFF >> rem)` (MSB = byte 0).
  - Each handshake subtracts min(16, rem) from rem.
  - The beat with rem≤16 is the last beat. AAD exits to PLD (if pld_len≠0) or LEN; PLD exits to LEN.
- **LEN**
  - `len_block` = {45'b0, aad_len, 3'b0, 29'b0, pld_len, 3'b0}, i.e. bit counts, 64 b each, AAD in the upper half.
  - Hold `len_valid` until `len_ready`, then go to TAG_WAIT.
- **TAG_WAIT**
  - Capture `tag_pre_xor` and `tagmask` independently, in any order or the same cycle, each with a sticky got-flag.
  - When both flags are set, go to TAG_OUT with `tag_out` = pre ⊕ mask and `tag_err`=0.
  - A timeout counter resets on entry. If it reaches TAG_TIMEOUT−1 without both flags set, go to TAG_OUT with `tag_out`=0 and `tag_err`=1.
  - Strobes arriving in any other state are ignored.
- **TAG_OUT**
  - `tag_valid`=1, with `tag_out` and `tag_err` stable, until `tag_ready`; then go to IDLE.
- **abort**
  - In any state except IDLE, `abort` forces IDLE on the next edge.
  - All got-flags, remaining counters and the timeout counter are cleared.
  - No tag is produced.
  - `abort` in IDLE is ignored and blocks job acceptance that cycle.
  - `abort` takes priority over every other transition.
- **algo_sel**
  - Registered; holds the latched `job_algo` from CFG through TAG_OUT.
  - Holds its last value in IDLE.

## Timing
- **Reset values (asynchronous):**
  - state=IDLE, all counters=0, flags=0, `algo_sel`=0, `tag_out`=0.
  - Every valid output and `cfg_we`=0.
  - `job_ready`=1 (decoded from IDLE), `busy`=0.
  - `in_ready`=0.
  - `aad_keep`/`pld_keep`=0 (decoded from state).
- **Registered vs combinational:**
  - State, counters, `len_block`, `tag_out`, `tag_err` and `algo_sel` are registered.
  - Stream valid/data/ready are combinational pass-through, gated by the state decode.
  - `*_keep` is combinational from the rem register.
- **Job acceptance to datapath:** `job_valid`&`job_ready` at edge N puts `cfg_we`=1 in cycle N+1; the first AAD/PLD beat can transfer at N+2.
- **Minimum overhead:** 4 cycles per job plus one cycle per beat (CFG, LEN handshake, one-cycle TAG_WAIT, TAG_OUT).
- **Back-to-back jobs:** `job_ready` rises the cycle after the `tag_valid`&`tag_ready` edge.
- **Stalls:** backpressure from either side stalls without any loss; rem only changes on a handshake.

## Test plan
- **Nominal AES job:** algo=0, aad=20, pld=32.
  - `cfg_we` high exactly 1 cycle.
  - `aad_keep` FFFF then F000.
  - `pld_keep` FFFF, FFFF.
  - `len_block` = 128'h00000000_000000A0_00000000_00000100.
  - With pre=0x…55, mask=0x…0F, `tag_out`=0x…5A and `tag_err`=0.
- **Zero-length ChaCha job:** algo=1, aad=0, pld=0.
  - CFG is followed directly by LEN with `len_block`=0.
  - No `aad_valid`/`pld_valid` pulses.
  - `algo_sel`=1 throughout.
- **Tag ordering:** `tagmask_valid` 5 cycles before `tag_pre_xor_valid`, then both strobes in the same cycle on a second job → correct XOR in both cases.
- **Timeout:** TAG_TIMEOUT=16 and no tag strobes → `tag_valid` with `tag_err`=1 and `tag_out`=0 exactly 16 cycles after TAG_WAIT entry.
- **Abort mid-payload:** abort on the 2nd of 4 PLD beats → IDLE next cycle with `in_ready`=0. A following job with pld=1 gives `pld_keep`=8000.
- **Backpressure:** random `in_valid`, `pld_ready` and `tag_ready` stalls → beat count and ordering match the descriptor; outputs are held stable while stalled.
